// File: rtl/dmem_port_arbiter_pkg.sv
// dmem_port_arbiter_pkg: FSM state encodings and owner ids shared by the dmem port arbiter
// and its winner-select sub-module.
package dmem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_PORT0 = 1'b0,
        ARB_PORT1 = 1'b1
    } arb_port_t;

endpackage

// File: rtl/dmem_port_arbiter_arb_pick.sv
// arb_pick: combinational winner select between the two dmem requesters.
// i_prefer1 breaks ties toward port 1 (starvation guard or round-robin pointer).
module arb_pick
    import dmem_port_arbiter_pkg::*;
(
    input  logic      i_en,
    input  logic      i_req0,
    input  logic      i_req1,
    input  logic      i_prefer1,
    output logic      o_gnt0,
    output logic      o_gnt1,
    output arb_port_t o_winner
);

    // Tie-break only on contention; a lone requester always wins.
    always_comb begin
        o_winner = ARB_PORT0;
        if (i_req0 && i_req1) begin
            o_winner = i_prefer1 ? ARB_PORT1 : ARB_PORT0;
        end else if (i_req1) begin
            o_winner = ARB_PORT1;
        end else begin
            o_winner = ARB_PORT0;
        end
        o_gnt0 = i_en && i_req0 && (o_winner == ARB_PORT0);
        o_gnt1 = i_en && i_req1 && (o_winner == ARB_PORT1);
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data-memory port between the CPU (port 0) and a secondary master (port 1).
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority with a starvation guard.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int               CNT_W    = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    generate
        if (MEM_LAT < 1) begin : g_bad_mem_lat
            $error("dmem_port_arbiter: MEM_LAT must be at least 1");
        end
    endgenerate

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_cap_we;
    logic [ADDR_W-1:0] r_cap_addr;
    logic [DATA_W-1:0] r_cap_wdata;
    logic [DATA_W-1:0] r_rdata;
    arb_port_t         r_owner;
    logic              w_arb_en;
    logic              w_prefer1;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_any_gnt;
    arb_port_t         w_winner;

    // Grants are suppressed while reset is held so every output reads 0 during reset.
    assign w_arb_en  = ((r_state == ARB_IDLE) || (r_state == ARB_RESP)) && !reset;
    assign w_any_gnt = w_gnt0 || w_gnt1;

    arb_pick u_arb_pick (
        .i_en      (w_arb_en),
        .i_req0    (m0_req),
        .i_req1    (m1_req),
        .i_prefer1 (w_prefer1),
        .o_gnt0    (w_gnt0),
        .o_gnt1    (w_gnt1),
        .o_winner  (w_winner)
    );

`ifdef ARB_ROUND_ROBIN_EN
    logic r_rr_pref;

    assign w_prefer1 = r_rr_pref;

    // Round-robin pointer: after each grant the other port is preferred.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_pref <= 1'b0;
        end else if (w_any_gnt) begin
            r_rr_pref <= (w_winner == ARB_PORT0);
        end
    end
`else
    localparam int STV_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [STV_W-1:0] r_starve;

    assign w_prefer1 = (r_starve == STV_W'(STARVE_LIMIT));

    // Starvation counter: counts port-1 losses, saturates at the limit, clears on a port-1 grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve <= '0;
        end else if (w_gnt1) begin
            r_starve <= '0;
        end else if (w_gnt0 && m1_req && !w_prefer1) begin
            r_starve <= r_starve + STV_W'(1);
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE:   w_next_state = w_any_gnt ? ARB_ACCESS : ARB_IDLE;
            ARB_ACCESS: w_next_state = (r_cnt == '0) ? ARB_RESP : ARB_ACCESS;
            ARB_RESP:   w_next_state = w_any_gnt ? ARB_ACCESS : ARB_IDLE;
            default:    w_next_state = ARB_IDLE;
        endcase
    end

    // Request capture at grant, access countdown, and read-data latch on the last access cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cap_we    <= 1'b0;
            r_cap_addr  <= '0;
            r_cap_wdata <= '0;
            r_owner     <= ARB_PORT0;
            r_cnt       <= '0;
            r_rdata     <= '0;
        end else begin
            if (w_any_gnt) begin
                r_cap_we    <= (w_winner == ARB_PORT1) ? m1_we    : m0_we;
                r_cap_addr  <= (w_winner == ARB_PORT1) ? m1_addr  : m0_addr;
                r_cap_wdata <= (w_winner == ARB_PORT1) ? m1_wdata : m0_wdata;
                r_owner     <= w_winner;
                r_cnt       <= CNT_LOAD;
            end else if ((r_state == ARB_ACCESS) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if ((r_state == ARB_ACCESS) && (r_cnt == '0)) begin
                r_rdata <= r_cap_we ? '0 : mem_rdata;
            end
        end
    end

    // FSM outputs: write strobe on the first access cycle, one-cycle response to the owner.
    always_comb begin
        m0_rvalid = 1'b0;
        m1_rvalid = 1'b0;
        m0_rdata  = '0;
        m1_rdata  = '0;
        mem_we    = 1'b0;
        busy      = 1'b0;
        case (r_state)
            ARB_ACCESS: begin
                mem_we = r_cap_we && (r_cnt == CNT_LOAD);
                busy   = 1'b1;
            end
            ARB_RESP: begin
                busy = 1'b1;
                if (r_owner == ARB_PORT0) begin
                    m0_rvalid = 1'b1;
                    m0_rdata  = r_rdata;
                end else begin
                    m1_rvalid = 1'b1;
                    m1_rdata  = r_rdata;
                end
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign m0_gnt    = w_gnt0;
    assign m1_gnt    = w_gnt1;
    assign mem_addr  = r_cap_addr;
    assign mem_wdata = r_cap_wdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed and randomized checks of dmem_port_arbiter against a
// transaction-level reference model (grant order, response timing, memory contents).
module tb_dmem_port_arbiter;

    localparam int LAT  = 3;
    localparam int SLIM = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        b_m0_req, b_m0_we, b_m0_gnt, b_m0_rvalid;
    logic [31:0] b_m0_addr, b_m0_wdata, b_m0_rdata;
    logic        b_m1_gnt, b_m1_rvalid;
    logic [31:0] b_m1_rdata;
    logic        b_mem_we, b_busy;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    logic [31:0] dmem [0:15];
    logic        tb_init;

    assign mem_rdata   = dmem[mem_addr[5:2]];
    assign b_mem_rdata = (b_mem_addr == 32'h10) ? 32'hDEADBEEF : 32'h0;

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 16; i++) dmem[i] <= 32'hC0DE0000 + i;
        end else if (mem_we) begin
            dmem[mem_addr[5:2]] <= mem_wdata;
        end
    end

    dmem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(LAT), .STARVE_LIMIT(SLIM)) u_dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    dmem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(1), .STARVE_LIMIT(SLIM)) u_dut1 (
        .clk(clk), .reset(reset),
        .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
        .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
        .m1_req(1'b0), .m1_we(1'b0), .m1_addr(32'h0), .m1_wdata(32'h0),
        .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .busy(b_busy)
    );

    typedef struct {
        int          due;
        int          port;
        logic [31:0] data;
    } rsp_t;

    int          checks, errors;
    int          ncyc, next_arb, starve, last_w, we_cnt;
    bit          rr_pref, rnd_mode;
    bit          p_req [2];
    bit          p_we [2];
    bit          auto_req [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_wdata [2];
    logic [31:0] refmem [0:15];
    rsp_t        rsp_q [$];
    bit          lg_valid, lg_we;
    int          lg_cycle;
    logic [31:0] cap_addr, cap_wdata, last_rd1;
    int          gnt_port_q [$];
    int          gnt_cyc_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        m0_req = p_req[0]; m0_we = p_we[0]; m0_addr = p_addr[0]; m0_wdata = p_wdata[0];
        m1_req = p_req[1]; m1_we = p_we[1]; m1_addr = p_addr[1]; m1_wdata = p_wdata[1];
    endtask

    task automatic issue(input int p, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        p_req[p] = 1'b1; p_we[p] = we; p_addr[p] = addr; p_wdata[p] = wdata;
        drive();
    endtask

    task automatic issue_rand(input int p);
        logic [3:0] idx;
        idx = 4'($urandom_range(15));
        issue(p, 1'($urandom_range(1)), {26'h0, idx, 2'b00}, $urandom);
    endtask

    task automatic model_clear();
        for (int p = 0; p < 2; p++) begin
            p_req[p] = 1'b0; auto_req[p] = 1'b0;
        end
        rnd_mode = 1'b0; starve = 0; rr_pref = 1'b0; lg_valid = 1'b0;
        cap_addr = 32'h0; cap_wdata = 32'h0; next_arb = ncyc; last_w = -1;
        rsp_q.delete(); gnt_port_q.delete(); gnt_cyc_q.delete();
    endtask

    // Reset with requests raised: nothing may be granted and every output must read 0.
    task automatic do_reset();
        reset = 1'b1;
        m0_req = 1'b1; m1_req = 1'b1;
        #1;
        chk("rst_gnt0", m0_gnt, 1'b0);
        chk("rst_gnt1", m1_gnt, 1'b0);
        chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_rdata", m0_rdata | m1_rdata, 32'h0);
        model_clear();
        drive();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    // One clock cycle: predict from the transaction model, compare, then advance the model.
    task automatic cycle();
        int          w;
        logic        e_rv0, e_rv1;
        logic [31:0] e_rd0, e_rd1;
        @(negedge clk); #1;
        w = -1;
        if (ncyc >= next_arb) begin
            if (p_req[0] && p_req[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
                w = rr_pref ? 1 : 0;
`else
                w = (starve == SLIM) ? 1 : 0;
`endif
            end else if (p_req[0]) begin
                w = 0;
            end else if (p_req[1]) begin
                w = 1;
            end
        end
        chk("gnt0", m0_gnt, w == 0);
        chk("gnt1", m1_gnt, w == 1);
        e_rv0 = 1'b0; e_rv1 = 1'b0; e_rd0 = 32'h0; e_rd1 = 32'h0;
        if (rsp_q.size() > 0 && rsp_q[0].due == ncyc) begin
            if (rsp_q[0].port == 0) begin
                e_rv0 = 1'b1; e_rd0 = rsp_q[0].data;
            end else begin
                e_rv1 = 1'b1; e_rd1 = rsp_q[0].data;
            end
            void'(rsp_q.pop_front());
        end
        chk("rvalid0", m0_rvalid, e_rv0);
        chk("rvalid1", m1_rvalid, e_rv1);
        chk("rdata0", m0_rdata, e_rd0);
        chk("rdata1", m1_rdata, e_rd1);
        if (m1_rvalid) last_rd1 = m1_rdata;
        chk("mem_we", mem_we, lg_valid && lg_we && (lg_cycle == ncyc - 1));
        chk("busy", busy, lg_valid && (ncyc > lg_cycle) && (ncyc <= lg_cycle + LAT + 1));
        chk("mem_addr", mem_addr, cap_addr);
        chk("mem_wdata", mem_wdata, cap_wdata);
        if (mem_we) we_cnt++;
        if (lg_valid && lg_we && (lg_cycle == ncyc - 1)) refmem[cap_addr[5:2]] = cap_wdata;
        if (w >= 0) begin
            if (w == 1) starve = 0;
            else if (p_req[1] && starve < SLIM) starve++;
            rr_pref = (w == 0);
            rsp_q.push_back('{ncyc + LAT + 1, w, p_we[w] ? 32'h0 : refmem[p_addr[w][5:2]]});
            lg_valid = 1'b1; lg_cycle = ncyc; lg_we = p_we[w];
            cap_addr = p_addr[w]; cap_wdata = p_wdata[w];
            next_arb = ncyc + LAT + 1;
            gnt_port_q.push_back(w); gnt_cyc_q.push_back(ncyc);
            p_req[w] = 1'b0;
        end
        last_w = w;
        @(posedge clk); #1;
        ncyc++;
        for (int p = 0; p < 2; p++) begin
            if (!p_req[p] && (auto_req[p] || (rnd_mode && $urandom_range(2) == 0))) issue_rand(p);
            else if (p_req[p] && rnd_mode && $urandom_range(15) == 0) p_req[p] = 1'b0;
        end
        drive();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        checks = 0; errors = 0; ncyc = 0; we_cnt = 0; last_rd1 = 32'h0;
        for (int i = 0; i < 16; i++) refmem[i] = 32'hC0DE0000 + i;
        for (int p = 0; p < 2; p++) begin
            p_we[p] = 1'b0; p_addr[p] = 32'h0; p_wdata[p] = 32'h0;
        end
        tb_init = 1'b1; reset = 1'b1;
        b_m0_req = 1'b0; b_m0_we = 1'b0; b_m0_addr = 32'h0; b_m0_wdata = 32'h0;
        model_clear();
        drive();
        @(posedge clk); #1;
        tb_init = 1'b0;
        do_reset();

        // Single load on the MEM_LAT=1 instance: gnt at T, rvalid at T+2.
        b_m0_req = 1'b1; b_m0_we = 1'b0; b_m0_addr = 32'h10;
        @(negedge clk); #1;
        chk("t1_gnt", b_m0_gnt, 1'b1);
        @(posedge clk); #1;
        b_m0_req = 1'b0;
        @(negedge clk); #1;
        chk("t1_rvalid_early", b_m0_rvalid, 1'b0);
        chk("t1_busy_access", b_busy, 1'b1);
        chk("t1_mem_addr", b_mem_addr, 32'h10);
        chk("t1_no_we", b_mem_we, 1'b0);
        @(negedge clk); #1;
        chk("t1_rvalid", b_m0_rvalid, 1'b1);
        chk("t1_rdata", b_m0_rdata, 32'hDEADBEEF);
        chk("t1_other_rvalid", b_m1_rvalid, 1'b0);
        @(negedge clk); #1;
        chk("t1_rvalid_once", b_m0_rvalid, 1'b0);
        chk("t1_idle", b_busy, 1'b0);
        @(posedge clk); #1;

        // Store then load through port 1.
        we_cnt = 0;
        issue(1, 1'b1, 32'h20, 32'h12345678);
        repeat (8) cycle();
        issue(1, 1'b0, 32'h20, 32'h0);
        repeat (8) cycle();
        chk("t2_we_pulses", we_cnt, 1);
        chk("t2_load_data", last_rd1, 32'h12345678);

        // Continuous contention.
        do_reset();
        issue_rand(0); issue_rand(1);
        auto_req[0] = 1'b1; auto_req[1] = 1'b1;
        repeat (45) cycle();
        auto_req[0] = 1'b0; auto_req[1] = 1'b0;
        repeat (10) cycle();
        chk("t3_grant_count", gnt_port_q.size() >= 10, 1'b1);
        for (int i = 0; i < 10 && i < gnt_port_q.size(); i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            chk("t3_order", gnt_port_q[i], i % 2);
`else
            chk("t3_order", gnt_port_q[i], (i % 5 == 4) ? 1 : 0);
`endif
        end

        // Back-to-back from port 0 alone.
        do_reset();
        issue_rand(0);
        auto_req[0] = 1'b1;
        repeat (22) cycle();
        auto_req[0] = 1'b0;
        repeat (6) cycle();
        chk("t5_grant_count", gnt_cyc_q.size() >= 5, 1'b1);
        for (int i = 1; i < 5 && i < gnt_cyc_q.size(); i++) begin
            chk("t5_gap", gnt_cyc_q[i] - gnt_cyc_q[i-1], LAT + 1);
        end

        // Randomized traffic including requests withdrawn before grant.
        do_reset();
        rnd_mode = 1'b1;
        repeat (600) cycle();
        rnd_mode = 1'b0;
        repeat (12) cycle();
        chk("rand_drained", rsp_q.size(), 0);

        // Reset during the access phase of a store.
        do_reset();
        issue(1, 1'b1, 32'h14, ~refmem[5]);
        k = 0;
        while (last_w != 1 && k < 10) begin
            cycle();
            k++;
        end
        chk("t6_granted", last_w, 1);
        chk("t6_we_in_access", mem_we, 1'b1);
        do_reset();
        chk("t6_mem_untouched", dmem[5], refmem[5]);
        repeat (8) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
